// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Lets two command sources share one 8-bit ALU (A,B,OP -> 16-bit R).
// Round-robin arbitration picks one command, the operands are held stable
// on the ALU inputs for ALU_LAT cycles, and the registered result is then
// returned to the winning requester over a valid/ready response channel.
module alu_share_arbiter #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [7:0]  req_a0,
  input  logic [7:0]  req_b0,
  input  logic [2:0]  req_op0,
  input  logic [7:0]  req_a1,
  input  logic [7:0]  req_b1,
  input  logic [2:0]  req_op1,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  input  logic [15:0] alu_r,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_id,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Value of the hold counter on the last cycle the operands must stay put
  localparam logic [3:0] LAST_CNT = 4'(ALU_LAT - 1);

  logic [1:0] state;
  logic       rr_ptr;
  logic [3:0] cnt;
  logic       id;
  logic       grant_id;
  logic       accept;

  // Grant logic: a lone requester wins outright, a tie goes to rr_ptr.
  // Ready is forced low while reset is asserted so every output reads 0.
  always_comb begin
    req_ready = 2'b00;
    grant_id  = 1'b0;
    if (rst_n && (state == IDLE)) begin
      case (req_valid)
        2'b01: begin
          req_ready = 2'b01;
          grant_id  = 1'b0;
        end
        2'b10: begin
          req_ready = 2'b10;
          grant_id  = 1'b1;
        end
        2'b11: begin
          grant_id  = rr_ptr;
          req_ready = rr_ptr ? 2'b10 : 2'b01;
        end
        default: begin
          req_ready = 2'b00;
          grant_id  = 1'b0;
        end
      endcase
    end
  end

  assign accept = |req_ready;

  // Transaction sequencer: accept in IDLE, hold operands in HOLD, then
  // present the captured result in RESP until its owner takes it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      cnt      <= 4'd0;
      id       <= 1'b0;
      alu_a    <= 8'd0;
      alu_b    <= 8'd0;
      alu_op   <= 3'd0;
      rsp_data <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a  <= grant_id ? req_a1  : req_a0;
            alu_b  <= grant_id ? req_b1  : req_b0;
            alu_op <= grant_id ? req_op1 : req_op0;
            id     <= grant_id;
            cnt    <= 4'd0;
            state  <= HOLD;
          end
        end
        HOLD: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAST_CNT) begin
            rsp_data <= alu_r;
            state    <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready[id]) begin
            rr_ptr <= ~id;
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Response valid is one-hot on the owner while the result is on offer
  always_comb begin
    rsp_valid = 2'b00;
    if (state == RESP) begin
      rsp_valid = id ? 2'b10 : 2'b01;
    end
  end

  assign rsp_id = id;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
// Directed bench for alu_share_arbiter. One instance runs with ALU_LAT=1,
// a second with ALU_LAT=4; both share clock, reset and request inputs and
// each drives its own behavioural ALU.
module tb_alu_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [7:0]  req_a0, req_b0, req_a1, req_b1;
  logic [2:0]  req_op0, req_op1;

  logic [1:0]  req_ready,  req_ready4;
  logic [7:0]  alu_a, alu_b, alu_a4, alu_b4;
  logic [2:0]  alu_op, alu_op4;
  logic [15:0] alu_r, alu_r4;
  logic [1:0]  rsp_valid, rsp_valid4;
  logic [1:0]  rsp_ready, rsp_ready4;
  logic [15:0] rsp_data, rsp_data4;
  logic        rsp_id, rsp_id4;
  logic        busy, busy4;

  int passed = 0;
  int total  = 0;
  logic [1:0]  exp_oh;
  logic [15:0] exp_data;

  // ALU model: 001 add, 010 multiply, 011 subtract, otherwise xor
  function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] op);
    case (op)
      3'b001:  alu_model = {8'h00, a} + {8'h00, b};
      3'b010:  alu_model = {8'h00, a} * {8'h00, b};
      3'b011:  alu_model = {8'h00, a} - {8'h00, b};
      default: alu_model = {8'h00, a ^ b};
    endcase
  endfunction

  assign alu_r  = alu_model(alu_a,  alu_b,  alu_op);
  assign alu_r4 = alu_model(alu_a4, alu_b4, alu_op4);

  alu_share_arbiter #(.ALU_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
    .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_r(alu_r),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  alu_share_arbiter #(.ALU_LAT(4)) u_lat4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready4),
    .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
    .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
    .alu_a(alu_a4), .alu_b(alu_b4), .alu_op(alu_op4), .alu_r(alu_r4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4),
    .rsp_data(rsp_data4), .rsp_id(rsp_id4), .busy(busy4)
  );

  // Free-running 10-time-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the shared request inputs
  task automatic applyStimulus(input logic [1:0] valid,
                               input logic [7:0] a0, input logic [7:0] b0, input logic [2:0] op0,
                               input logic [7:0] a1, input logic [7:0] b1, input logic [2:0] op1);
    req_valid = valid;
    req_a0 = a0; req_b0 = b0; req_op0 = op0;
    req_a1 = a1; req_b1 = b1; req_op1 = op1;
  endtask

  // One comparison point
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total = total + 1;
    assert (obs === expv) passed = passed + 1;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  initial begin
    // T1: reset with both requesters valid
    rst_n      = 1'b0;
    rsp_ready  = 2'b00;
    rsp_ready4 = 2'b00;
    applyStimulus(2'b11, 8'h12, 8'h34, 3'b001, 8'h56, 8'h78, 3'b001);
    tick();
    tick();
    checkOutput("t1_req_ready", 32'(req_ready), 32'h0);
    checkOutput("t1_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("t1_rsp_data",  32'(rsp_data),  32'h0);
    checkOutput("t1_rsp_id",    32'(rsp_id),    32'h0);
    checkOutput("t1_busy",      32'(busy),      32'h0);
    checkOutput("t1_alu_ops",   {13'h0, alu_op, alu_a, alu_b}, 32'h0);
    checkOutput("t1_busy4",     32'(busy4),     32'h0);

    // T2: single op from requester 0, 0x12 + 0x34
    rst_n = 1'b1;
    applyStimulus(2'b01, 8'h12, 8'h34, 3'b001, 8'h00, 8'h00, 3'b000);
    #1;
    checkOutput("t2_req_ready", 32'(req_ready), 32'h1);
    tick();
    applyStimulus(2'b00, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 3'b000);
    #1;
    checkOutput("t2_hold_busy",  32'(busy),      32'h1);
    checkOutput("t2_hold_valid", 32'(rsp_valid), 32'h0);
    checkOutput("t2_hold_ready", 32'(req_ready), 32'h0);
    checkOutput("t2_alu_a",      32'(alu_a),     32'h12);
    tick();
    checkOutput("t2_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("t2_rsp_data",  32'(rsp_data),  32'h0046);
    checkOutput("t2_rsp_id",    32'(rsp_id),    32'h0);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    checkOutput("t2_done_busy",  32'(busy),      32'h0);
    checkOutput("t2_done_valid", 32'(rsp_valid), 32'h0);

    // T3: both requesters valid from reset, grants must alternate
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    applyStimulus(2'b11, 8'h01, 8'h02, 3'b001, 8'hFF, 8'hFF, 3'b010);
    rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_oh   = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_data = (i % 2 == 0) ? 16'h0003 : 16'hFE01;
      #1;
      checkOutput("t3_grant", 32'(req_ready), 32'(exp_oh));
      tick();
      checkOutput("t3_hold_ready", 32'(req_ready), 32'h0);
      tick();
      checkOutput("t3_rsp_valid", 32'(rsp_valid), 32'(exp_oh));
      checkOutput("t3_rsp_data",  32'(rsp_data),  32'(exp_data));
      checkOutput("t3_rsp_id",    32'(rsp_id),    32'(i % 2));
      checkOutput("t3_resp_ready", 32'(req_ready), 32'h0);
      tick();
    end

    // T4: backpressure on a requester-0 response, stray rsp_ready[1] pulse
    rsp_ready = 2'b00;
    #1;
    checkOutput("t4_grant", 32'(req_ready), 32'h1);
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      rsp_ready = (k == 2) ? 2'b10 : 2'b00;
      #1;
      checkOutput("t4_rsp_valid", 32'(rsp_valid), 32'h1);
      checkOutput("t4_rsp_data",  32'(rsp_data),  32'h0003);
      checkOutput("t4_req_ready", 32'(req_ready), 32'h0);
      checkOutput("t4_busy",      32'(busy),      32'h1);
      tick();
    end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    checkOutput("t4_after_busy",  32'(busy),      32'h0);
    checkOutput("t4_after_grant", 32'(req_ready), 32'h2);
    applyStimulus(2'b00, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 3'b000);

    // T5: ALU_LAT=4 instance, operands frozen after accept, 5-cycle latency
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    applyStimulus(2'b01, 8'h10, 8'h20, 3'b001, 8'h00, 8'h00, 3'b000);
    #1;
    checkOutput("t5_req_ready", 32'(req_ready4), 32'h1);
    tick();
    applyStimulus(2'b00, 8'hAA, 8'h20, 3'b001, 8'h00, 8'h00, 3'b000);
    #1;
    checkOutput("t5_alu_a_held", 32'(alu_a4), 32'h10);
    for (int k = 1; k <= 4; k++) begin
      checkOutput("t5_no_rsp_yet", 32'(rsp_valid4), 32'h0);
      tick();
    end
    checkOutput("t5_rsp_valid", 32'(rsp_valid4), 32'h1);
    checkOutput("t5_rsp_data",  32'(rsp_data4),  32'h0030);
    checkOutput("t5_rsp_id",    32'(rsp_id4),    32'h0);
    checkOutput("t5_alu_a_end", 32'(alu_a4),     32'h10);
    rsp_ready4 = 2'b01;
    tick();
    rsp_ready4 = 2'b00;

    // T6: reset in the middle of HOLD drops the transaction and rr_ptr
    applyStimulus(2'b10, 8'h00, 8'h00, 3'b000, 8'h05, 8'h06, 3'b001);
    #1;
    checkOutput("t6_req_ready", 32'(req_ready4), 32'h2);
    tick();
    applyStimulus(2'b00, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 3'b000);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("t6_busy",      32'(busy4),      32'h0);
    checkOutput("t6_rsp_valid", 32'(rsp_valid4), 32'h0);
    checkOutput("t6_alu_a",     32'(alu_a4),     32'h0);
    for (int k = 0; k < 6; k++) begin
      tick();
      checkOutput("t6_no_rsp", 32'(rsp_valid4), 32'h0);
    end
    applyStimulus(2'b11, 8'h01, 8'h01, 3'b001, 8'h02, 8'h02, 3'b001);
    #1;
    checkOutput("t6_tie_grant", 32'(req_ready4), 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
